// File: rtl/zone_alarm_ctrl.sv
// Multi-zone arm/exit/entry/alarm controller with latched tripped-zone report.
// All outputs registered (1 cycle after the qualifying edge); no backpressure. Optional tamper input: ZONE_ALARM_TAMPER_EN.
module zone_alarm_ctrl #(
    parameter int                 NUM_ZONES    = 4,
    parameter int                 CNT_W        = 8,
    parameter int                 EXIT_DELAY   = 16,
    parameter int                 ENTRY_DELAY  = 32,
    parameter logic [NUM_ZONES-1:0] INSTANT_MASK = 4'b0001
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arm,
    input  logic                 disarm,
    input  logic [NUM_ZONES-1:0] zone,
    input  logic [NUM_ZONES-1:0] zone_en,
`ifdef ZONE_ALARM_TAMPER_EN
    input  logic                 tamper,
    output logic                 tamper_flag,
`endif
    output logic                 alarm,
    output logic [2:0]           state,
    output logic [NUM_ZONES-1:0] tripped,
    output logic [CNT_W-1:0]     timer
);

    typedef enum logic [2:0] {
        S_DISARMED = 3'd0,
        S_EXIT     = 3'd1,
        S_ARMED    = 3'd2,
        S_ENTRY    = 3'd3,
        S_ALARM    = 3'd4
    } state_t;

    state_t                 r_state;
    logic                   r_alarm;
    logic [NUM_ZONES-1:0]   r_tripped;
    logic [CNT_W-1:0]       r_timer;

    state_t                 w_nxt_state;
    logic [NUM_ZONES-1:0]   w_nxt_tripped;
    logic [CNT_W-1:0]       w_nxt_timer;
    logic [NUM_ZONES-1:0]   w_act;
    logic                   w_inst;
    logic                   w_any;
    logic                   w_disarm_ok;

    assign w_act  = zone & zone_en;
    assign w_inst = |(w_act & INSTANT_MASK);
    assign w_any  = |w_act;

`ifdef ZONE_ALARM_TAMPER_EN
    logic r_tamper_flag;
    // An active tamper pins the controller in ALARM, so disarm only works once it clears.
    assign w_disarm_ok = disarm & ~tamper;
`else
    assign w_disarm_ok = disarm;
`endif

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_timer   = r_timer;
        w_nxt_tripped = r_tripped;
        case (r_state)
            S_DISARMED: begin
                if (arm && !disarm) begin
                    w_nxt_state   = S_EXIT;
                    w_nxt_timer   = CNT_W'(EXIT_DELAY);
                    w_nxt_tripped = '0;
                end
            end
            S_EXIT: begin
                if (disarm) begin
                    w_nxt_state = S_DISARMED;
                    w_nxt_timer = '0;
                end else if (r_timer == '0) begin
                    w_nxt_state = S_ARMED;
                end else begin
                    w_nxt_timer = r_timer - CNT_W'(1);
                end
            end
            S_ARMED: begin
                if (disarm) begin
                    w_nxt_state = S_DISARMED;
                end else if (w_inst) begin
                    w_nxt_state   = S_ALARM;
                    w_nxt_tripped = r_tripped | w_act;
                end else if (w_any) begin
                    w_nxt_state   = S_ENTRY;
                    w_nxt_timer   = CNT_W'(ENTRY_DELAY);
                    w_nxt_tripped = r_tripped | w_act;
                end
            end
            S_ENTRY: begin
                w_nxt_tripped = r_tripped | w_act;
                if (disarm) begin
                    w_nxt_state = S_DISARMED;
                    w_nxt_timer = '0;
                end else if (w_inst || r_timer == '0) begin
                    w_nxt_state = S_ALARM;
                    w_nxt_timer = '0;
                end else begin
                    w_nxt_timer = r_timer - CNT_W'(1);
                end
            end
            S_ALARM: begin
                w_nxt_tripped = r_tripped | w_act;
                w_nxt_timer   = '0;
                if (w_disarm_ok) begin
                    w_nxt_state = S_DISARMED;
                end
            end
            default: begin
                w_nxt_state = S_DISARMED;
                w_nxt_timer = '0;
            end
        endcase
`ifdef ZONE_ALARM_TAMPER_EN
        if (tamper) begin
            w_nxt_state = S_ALARM;
            w_nxt_timer = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_DISARMED;
            r_alarm   <= 1'b0;
            r_tripped <= '0;
            r_timer   <= '0;
        end else begin
            r_state   <= w_nxt_state;
            r_alarm   <= (w_nxt_state == S_ALARM);
            r_tripped <= w_nxt_tripped;
            r_timer   <= w_nxt_timer;
        end
    end

`ifdef ZONE_ALARM_TAMPER_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tamper_flag <= 1'b0;
        end else if (tamper) begin
            r_tamper_flag <= 1'b1;
        end
    end

    assign tamper_flag = r_tamper_flag;
`endif

    assign alarm   = r_alarm;
    assign state   = r_state;
    assign tripped = r_tripped;
    assign timer   = r_timer;

endmodule
